alu_writeback_seq: RTL

Upstream write-side sequencer for the 4x4 register bank. Takes a raw push-button "execute" input, the op/destination switches and the two read-port values (rs1, rs2). Performs one 4-bit ALU operation per debounced press. Drives the bank's write port (RegWrite, Write_register, ALU_data) with exactly one RegWrite cycle per press.

---
 rtl/alu_writeback_seq.sv | 90 +++++++++
 1 files changed

// File: rtl/alu_writeback_seq.sv
// alu_writeback_seq: debounced push-button sequencer issuing one ALU op and one bank write per press
module alu_writeback_seq #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       exec_btn,
  input  logic [1:0] op,
  input  logic [1:0] dest,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  output logic       RegWrite,
  output logic [1:0] Write_register,
  output logic [3:0] ALU_data,
  output logic       carry,
  output logic       zero,
  output logic       busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, EXEC, WRITE, RELEASE} state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d, deb_prev_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          flip, press, start, exec;
  logic [1:0]    op_q, op_d, dest_q, dest_d;
  logic [3:0]    a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic          carry_q, carry_d, zero_q, zero_d;
  logic [4:0]    sum, diff, res;
  always_comb begin
    sync_d  = {sync_q[0], exec_btn};
    cnt_inc = cnt_q + CW'(1);
    flip    = (sync_q[1] != deb_q) && (cnt_inc == CW'(DEBOUNCE_CYCLES));
    cnt_d   = (sync_q[1] == deb_q || flip) ? '0 : cnt_inc;
    deb_d   = deb_q ^ flip;
    press   = deb_q & ~deb_prev_q;
    start   = (state_q == IDLE) && press;
    exec    = (state_q == EXEC);
    op_d    = start ? op : op_q;
    dest_d  = start ? dest : dest_q;
    a_d     = start ? rs1 : a_q;
    b_d     = start ? rs2 : b_q;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    // bit 4 of res is the carry flag; for SUB it is the inverted borrow
    res     = (op_q == 2'd0) ? sum :
              (op_q == 2'd1) ? {~diff[4], diff[3:0]} :
              (op_q == 2'd2) ? {1'b0, a_q & b_q} : {1'b0, a_q | b_q};
    alu_d   = exec ? res[3:0] : alu_q;
    carry_d = exec ? res[4] : carry_q;
    zero_d  = exec ? (res[3:0] == 4'd0) : zero_q;
    state_d = (state_q == IDLE) ? (press ? EXEC : IDLE) :
              (state_q == EXEC) ? WRITE : (deb_q ? RELEASE : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
      op_q       <= '0;
      dest_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
    end
  end
  assign RegWrite       = (state_q == WRITE);
  assign busy           = (state_q != IDLE);
  assign Write_register = dest_q;
  assign ALU_data       = alu_q;
  assign carry          = carry_q;
  assign zero           = zero_q;
endmodule
